// File: rtl/msg_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module   : msg_frame_decoder
// Purpose  : Frames bytes from a UART receiver on a terminator character and
//            decodes IFM fault messages ("IFM-E/C/R...") and PBM pick-block
//            messages ("PBM-SU-Bn-..."). Fault flags are stretched to a fixed
//            pulse width. The pick request is sticky until acknowledged.
//            Overflow, unknown headers and bad locations pulse frame_err.
// Ports    : clk_50M         in   system clock
//            rst             in   asynchronous active-high reset
//            rx_msg[7:0]     in   received byte, valid while rx_complete high
//            rx_complete     in   level; each rising edge delivers one byte
//            pick_ack        in   control FSM consumed the pick request
//            EU/CU/RU_fault_flag out  fault flags, FAULT_PULSE cycles each
//            pick_block_flag out  sticky pick request
//            block_location  out  location index of the latest valid PBM
//            frame_err       out  one-cycle error pulse
//            busy            out  high while not collecting
// Revision : 1.0 - initial release
// ============================================================================
module msg_frame_decoder #(
    parameter int         MAX_LEN     = 12,
    parameter logic [7:0] TERM_CHAR   = 8'h23,
    parameter int         FAULT_PULSE = 4,
    parameter int         NUM_LOC     = 4,
    parameter logic [7:0] LOC_BASE    = 8'h31,
    localparam int        LOC_W       = (NUM_LOC > 1) ? $clog2(NUM_LOC) : 1
) (
    input  logic             clk_50M,
    input  logic             rst,
    input  logic [7:0]       rx_msg,
    input  logic             rx_complete,
    input  logic             pick_ack,
    output logic             EU_fault_flag,
    output logic             CU_fault_flag,
    output logic             RU_fault_flag,
    output logic             pick_block_flag,
    output logic [LOC_W-1:0] block_location,
    output logic             frame_err,
    output logic             busy
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int CNT_W = $clog2(FAULT_PULSE + 1);

    localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(MAX_LEN - 1);
    localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(FAULT_PULSE);
    localparam logic [8:0]       c_num_loc  = 9'(NUM_LOC);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_DECODE  = 2'd1,
        ST_CLEAR   = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t           r_state;
    logic [7:0]       r_buf [MAX_LEN];
    logic [IDX_W-1:0] r_idx;
    logic [CNT_W-1:0] r_fault_cnt;
    logic             r_rx_prev;
    logic             r_pending;
    logic [7:0]       r_hold;

    logic       w_strobe;
    logic       w_have;
    logic [7:0] w_byte;
    logic       w_is_term;
    logic       w_ifm;
    logic       w_pbm;
    logic [7:0] w_loc_off;
    logic       w_loc_ok;
    logic       w_fault_hit;

    assign w_strobe  = rx_complete & ~r_rx_prev;
    // A byte held from a busy period is always consumed before a fresh one.
    assign w_have    = r_pending | w_strobe;
    assign w_byte    = r_pending ? r_hold : rx_msg;
    assign w_is_term = (w_byte == TERM_CHAR);

    assign w_ifm     = ({r_buf[0], r_buf[1], r_buf[2], r_buf[3]} == "IFM-");
    assign w_pbm     = ({r_buf[0], r_buf[1], r_buf[2], r_buf[3],
                         r_buf[4], r_buf[5], r_buf[6], r_buf[7]} == "PBM-SU-B");
    assign w_loc_off = r_buf[8] - LOC_BASE;
    assign w_loc_ok  = (r_buf[8] >= LOC_BASE) && ({1'b0, w_loc_off} < c_num_loc);
    assign w_fault_hit = (r_state == ST_DECODE) && w_ifm &&
                         ((r_buf[4] == 8'h45) || (r_buf[4] == 8'h43) || (r_buf[4] == 8'h52));

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_state         <= ST_COLLECT;
            for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= 8'h00;
            r_idx           <= '0;
            r_fault_cnt     <= '0;
            r_rx_prev       <= 1'b0;
            r_pending       <= 1'b0;
            r_hold          <= 8'h00;
            EU_fault_flag   <= 1'b0;
            CU_fault_flag   <= 1'b0;
            RU_fault_flag   <= 1'b0;
            pick_block_flag <= 1'b0;
            block_location  <= '0;
            frame_err       <= 1'b0;
            busy            <= 1'b0;
        end else begin
            r_rx_prev <= rx_complete;
            frame_err <= 1'b0;

            // A new fault reloads the counter, so earlier flags survive until
            // the reloaded pulse expires.
            if (w_fault_hit) begin
                r_fault_cnt <= c_cnt_load;
            end else if (r_fault_cnt != '0) begin
                r_fault_cnt <= r_fault_cnt - CNT_W'(1);
                if (r_fault_cnt == CNT_W'(1)) begin
                    EU_fault_flag <= 1'b0;
                    CU_fault_flag <= 1'b0;
                    RU_fault_flag <= 1'b0;
                end
            end

            // A PBM decode in the same cycle is assigned later and wins.
            if (pick_ack) pick_block_flag <= 1'b0;

            case (r_state)
                ST_COLLECT, ST_DISCARD: begin
                    if (w_have) begin
                        // A strobe arriving while the held byte drains replaces it.
                        r_pending <= r_pending & w_strobe;
                        if (r_pending & w_strobe) r_hold <= rx_msg;
                        if (r_state == ST_COLLECT) begin
                            r_buf[r_idx] <= w_byte;
                            if (w_is_term) begin
                                r_idx   <= '0;
                                r_state <= ST_DECODE;
                                busy    <= 1'b1;
                            end else if (r_idx == c_idx_last) begin
                                frame_err <= 1'b1;
                                r_idx     <= '0;
                                r_state   <= ST_DISCARD;
                                busy      <= 1'b1;
                            end else begin
                                r_idx <= r_idx + IDX_W'(1);
                            end
                        end else if (w_is_term) begin
                            r_state <= ST_CLEAR;
                        end
                    end
                end
                ST_DECODE: begin
                    if (w_fault_hit) begin
                        if (r_buf[4] == 8'h45) EU_fault_flag <= 1'b1;
                        if (r_buf[4] == 8'h43) CU_fault_flag <= 1'b1;
                        if (r_buf[4] == 8'h52) RU_fault_flag <= 1'b1;
                    end else if (w_pbm && w_loc_ok) begin
                        pick_block_flag <= 1'b1;
                        block_location  <= w_loc_off[LOC_W-1:0];
                    end else begin
                        frame_err <= 1'b1;
                    end
                    r_state <= ST_CLEAR;
                end
                ST_CLEAR: begin
                    for (int i = 0; i < MAX_LEN; i++) r_buf[i] <= 8'h00;
                    r_state <= ST_COLLECT;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= ST_COLLECT;
                    busy    <= 1'b0;
                end
            endcase

            // Bytes arriving while decoding or clearing wait in a one-byte
            // hold register; a second one has nowhere to go and is dropped.
            if (w_strobe && ((r_state == ST_DECODE) || (r_state == ST_CLEAR))) begin
                if (r_pending) begin
                    frame_err <= 1'b1;
                end else begin
                    r_pending <= 1'b1;
                    r_hold    <= rx_msg;
                end
            end
        end
    end

endmodule
`default_nettype wire
